// File: rtl/gpio_wr_arbiter.sv
// gpio_wr_arbiter
//   Round-robin arbiter that funnels NREQ write requesters onto a single GPIO
//   register write port. Each grant issues a one-cycle write strike, followed
//   by GAP idle cycles before the next request can be sampled.
//
//   state | meaning
//   IDLE  | waiting; req sampled every rising edge
//   WRITE | one-cycle write strike, ack to the granted requester
//   HOLD  | GAP enforced idle cycles after a write
//
// Ports
//   clk       : clock, all state updates on rising edge
//   rst       : asynchronous active-high reset
//   req       : per-requester level request, held until acked
//   req_data  : requester i's data at [i*DW +: DW]
//   ack       : one-hot pulse to the granted requester during WRITE
//   we        : GPIO register write strike
//   wdata     : GPIO register write data (captured at grant)
//   busy      : high whenever the FSM is not in IDLE
//   grant_id  : index of the most recent grant
module gpio_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           ack,
  output logic                      we,
  output logic [DW-1:0]             wdata,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam logic [3:0] HOLD_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   last_grant;
  logic [DW-1:0]   data_q;
  logic [3:0]      cnt_q;
  logic [GW-1:0]   winner;
  logic [DW-1:0]   winner_data;
  logic            found;
  logic [GW:0]     cand;

  // Round-robin search starting one past the last grant, wrapping at NREQ.
  // cand carries one extra bit so last_grant + i never overflows before
  // the modulo subtraction.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (GW+1)'(i);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!found && req[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
    winner_data = req_data[winner*DW +: DW];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = WRITE;
      WRITE:   state_d = (GAP > 0) ? HOLD : IDLE;
      HOLD:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_grant <= GW'(NREQ - 1);
      data_q     <= '0;
      cnt_q      <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        last_grant <= winner;
        data_q     <= winner_data;
      end
      // Loaded on HOLD entry; reaches 0 in the last of the GAP HOLD cycles.
      if (state_q == WRITE) begin
        cnt_q <= HOLD_LOAD;
      end else if (state_q == HOLD && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Outputs depend only on registered state, never on req.
  always_comb begin
    ack = '0;
    if (state_q == WRITE) begin
      ack[last_grant] = 1'b1;
    end
  end

  assign we       = (state_q == WRITE);
  assign wdata    = data_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = last_grant;

endmodule

// File: tb/tb_gpio_wr_arbiter.sv
module tb_gpio_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int GW   = $clog2(NREQ);

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      ack;
  logic                 we;
  logic [DW-1:0]        wdata;
  logic                 busy;
  logic [GW-1:0]        grant_id;

  logic                 rst_z;
  logic [NREQ-1:0]      req_z;
  logic [NREQ*DW-1:0]   data_z;
  logic [NREQ-1:0]      ack_z;
  logic                 we_z;
  logic [DW-1:0]        wdata_z;
  logic                 busy_z;
  logic [GW-1:0]        gid_z;

  gpio_wr_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .we(we), .wdata(wdata), .busy(busy), .grant_id(grant_id)
  );

  gpio_wr_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst_z), .req(req_z), .req_data(data_z),
    .ack(ack_z), .we(we_z), .wdata(wdata_z), .busy(busy_z), .grant_id(gid_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction view of the arbiter.
  int          m_last;
  int          m_remain;
  logic [DW-1:0] m_data;
  bit          m_we;
  int          cyc;
  int          waits[NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = NREQ - 1;
    m_data   = '0;
    m_remain = 0;
    m_we     = 0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'(NREQ - 1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Advance one clock: predict from the req seen at this edge, then compare.
  task automatic tick();
    int  w;
    bit  fnd;
    for (int i = 0; i < NREQ; i++) if (!req[i]) waits[i] = 0;
    if (m_remain == 0) begin
      fnd = 0;
      w   = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!fnd && req[c]) begin
          fnd = 1;
          w   = c;
        end
      end
      m_we = fnd;
      if (fnd) begin
        m_last   = w;
        m_data   = req_data[w*DW +: DW];
        m_remain = 1 + GAP;
      end
    end else begin
      m_remain--;
      m_we = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("we", 32'(we), 32'(m_we));
    check("ack", 32'(ack), m_we ? (32'd1 << m_last) : 32'd0);
    check("wdata", 32'(wdata), 32'(m_data));
    check("busy", 32'(busy), 32'(m_remain > 0));
    check("grant_id", 32'(grant_id), 32'(m_last));
    if (ack != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) waits[i] = 0;
        else if (req[i]) begin
          waits[i]++;
          check("fair_wait", 32'(waits[i] <= NREQ - 1), 32'd1);
        end
      end
    end
  endtask

  initial begin
    int n;
    int prev;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    rst_z    = 1'b1;
    req_z    = '0;
    data_z   = '0;
    cyc      = 0;
    model_reset();

    // Single request from requester 2
    do_reset();
    req = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    tick();
    check("single_we", 32'(we), 32'd1);
    check("single_wdata", 32'(wdata), 32'hA5);
    check("single_ack", 32'(ack), 32'b0100);
    req = '0;
    for (int t = 0; t < 4; t++) tick();

    // All requesting, each drops after its ack
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
    n = 0;
    prev = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (we === 1'b1) begin
        check("rr_order", 32'(grant_id), 32'(n));
        if (prev >= 0) check("spacing", 32'(cyc - prev), 32'(2 + GAP));
        prev = cyc;
        n++;
        req[m_last] = 1'b0;
      end
    end
    check("rr_count", 32'(n), 32'd4);

    // Fairness between 0 and 3 held continuously
    do_reset();
    req = 4'b1001;
    n = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      if (we === 1'b1) begin
        check("alt_order", 32'(grant_id), (n % 2 == 0) ? 32'd0 : 32'd3);
        n++;
      end
    end
    check("alt_count", 32'(n), 32'd8);

    // Data captured at grant is not disturbed afterwards
    do_reset();
    req = 4'b0010;
    req_data[1*DW +: DW] = 8'h3C;
    tick();
    req_data[1*DW +: DW] = 8'hFF;
    req = '0;
    #1;
    check("data_stable", 32'(wdata), 32'h3C);
    tick();
    tick();

    // Reset in the middle of a write
    do_reset();
    req = 4'b0001;
    req_data[0 +: DW] = 8'h5A;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_gid", 32'(grant_id), 32'd3);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("post_rst_we", 32'(we), 32'd0);
    tick();
    req = '0;
    for (int t = 0; t < 4; t++) tick();

    // Randomised traffic against the model
    do_reset();
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
        req_data[i*DW +: DW] = DW'($urandom);
      end
      tick();
      if (m_we) req[m_last] = 1'b0;
    end

    // GAP=0 build: continuous 0011 alternates every second cycle
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst_z  = 1'b0;
    req_z  = 4'b0011;
    data_z = {8'h00, 8'h00, 8'h22, 8'h11};
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c % 2 == 1) begin
        check("g0_we", 32'(we_z), 32'd1);
        check("g0_ack", 32'(ack_z), (((c - 1) / 2) % 2 == 0) ? 32'd1 : 32'd2);
        check("g0_wdata", 32'(wdata_z), (((c - 1) / 2) % 2 == 0) ? 32'h11 : 32'h22);
      end else begin
        check("g0_we_idle", 32'(we_z), 32'd0);
        check("g0_ack_idle", 32'(ack_z), 32'd0);
      end
    end
    rst_z = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_wr_arbiter.md
GPIO_WR_ARBITER -- requirements
Module: gpio_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 Parameter DW, default 8: write data width, matching the GPIO register width.
REQ-003 Parameter GAP, default 2: idle cycles enforced after each write (0..15).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port req, input, NREQ: per-requester write request, level, held until acked.
REQ-007 Port req_data, input, NREQ*DW: requester i's data occupies bits [i*DW +: DW].
REQ-008 Port ack, output, NREQ: one-hot, one-cycle pulse to the granted requester when its write issues.
REQ-009 Port we, output, 1: write strike to the GPIO register.
REQ-010 Port wdata, output, DW: write data to the GPIO register, valid while we=1.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 Port grant_id, output, clog2(NREQ): index of the most recent grant.

Function
REQ-013 FSM states SHALL be IDLE, WRITE and HOLD, encoded in registers.
REQ-014 IDLE: if any req bit is sampled high at a rising edge, go to WRITE; otherwise remain in IDLE.
REQ-015 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod NREQ and wraps; the first set req bit wins.
REQ-016 On the IDLE->WRITE edge, last_grant <= winner and data_q <= winner's req_data slice.
REQ-017 WRITE SHALL last exactly one cycle, with we=1, wdata=data_q, ack[last_grant]=1 and all other ack bits 0.
REQ-018 WRITE->HOLD if GAP>0; WRITE->IDLE if GAP=0.
REQ-019 HOLD: a 4-bit counter loads GAP-1 on entry and decrements each cycle; exit to IDLE in the cycle after it reads 0, giving exactly GAP HOLD cycles.
REQ-020 Outside WRITE: we=0, ack=0, wdata=data_q.
REQ-021 we and ack SHALL be decoded only from registered state, with no combinational path from req.
REQ-022 Latency: req sampled at edge k in IDLE -> we/ack high during cycle k+1.
REQ-023 Minimum write spacing SHALL be 2+GAP cycles, measured from one we rising edge to the next.
REQ-024 Requester protocol: a requester drops req in the cycle after ack. A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-025 A req dropped before it is sampled in IDLE SHALL produce no write and no ack.
REQ-026 req_data changes after the grant edge SHALL NOT affect wdata.
REQ-027 req changes during WRITE or HOLD SHALL be ignored until IDLE.
REQ-028 Simultaneous requests SHALL cause exactly one grant per WRITE; the others wait.
REQ-029 No requester SHALL wait more than NREQ-1 grants while holding req high.
REQ-030 grant_id SHALL equal last_grant at all times.

Reset
REQ-031 While rst=1, all outputs and state are forced immediately, independent of clk: state=IDLE, last_grant=NREQ-1, data_q=0, counter=0.
REQ-032 Reset output values: we=0, ack=0, wdata=0, busy=0, grant_id=NREQ-1.
REQ-033 rst asserted during WRITE SHALL drop we/ack within the same cycle; the interrupted write is not re-issued.
REQ-034 After rst deasserts, the first sampled request is arbitrated with req[0] at highest priority.

Verification
REQ-035 Single request: after reset, req=4'b0100 with data slice 2=8'hA5 -> one cycle later we=1, wdata=8'hA5, ack=4'b0100, grant_id=2; busy high for 1+GAP=3 cycles.
REQ-036 All requesting: req=4'b1111 held, each dropped one cycle after its ack -> grant order 0,1,2,3; we pulses spaced exactly 4 cycles apart with GAP=2.
REQ-037 Fairness: req0 and req3 both held high continuously -> grants alternate 0,3,0,3; neither is granted twice in a row.
REQ-038 Data stability: req1 data=8'h3C at grant, changed to 8'hFF in the WRITE cycle -> wdata=8'h3C.
REQ-039 Mid-write reset: rst pulsed during WRITE -> we=0 and ack=0 immediately; grant_id=3; no we for a request re-presented after reset until it is resampled in IDLE.
REQ-040 GAP=0 build: continuous req=4'b0011 -> we high every 2nd cycle, acks alternating 0,1.
